// File: rtl/nco_i2c_pkg.sv
// nco_i2c_pkg: control-bit positions, group sizes, FSM state encoding and the
// byte-count helper shared by the NCO I2C configuration master.
package nco_i2c_pkg;

    localparam int CTRL_E = 0;
    localparam int CTRL_S = 1;
    localparam int CTRL_F = 2;
    localparam int CTRL_D = 3;

    localparam int FREQ_BYTES = 8;
    localparam int DUTY_BYTES = 2;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE    = 4'd0;
    localparam state_t ST_START_A = 4'd1;
    localparam state_t ST_START_B = 4'd2;
    localparam state_t ST_BIT     = 4'd3;
    localparam state_t ST_ACK     = 4'd4;
    localparam state_t ST_STOP_A  = 4'd5;
    localparam state_t ST_STOP_B  = 4'd6;
    localparam state_t ST_STOP_C  = 4'd7;
    localparam state_t ST_DONE    = 4'd8;

    function automatic logic [3:0] n_bytes(input logic f, input logic d);
        n_bytes = 4'd2 + (f ? 4'(FREQ_BYTES) : 4'd0) + (d ? 4'(DUTY_BYTES) : 4'd0);
    endfunction

endpackage

// File: rtl/nco_i2c_cfg_master_tick.sv
// i2c_quarter_tick: SCL quarter-period divider; 'hold' freezes the count so a
// stretched SCL low phase extends the current quarter.
module i2c_quarter_tick #(
    parameter int unsigned QUARTER = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic hold,
    output logic tick
);

    logic [15:0] cnt_r;
    logic        at_end_s;

    assign at_end_s = (cnt_r == 16'(QUARTER - 1));
    assign tick     = run && !hold && at_end_s;

    // Quarter counter: idles at zero, wraps on each tick, frozen while held.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 16'd0;
        end else if (!run) begin
            cnt_r <= 16'd0;
        end else if (hold) begin
            cnt_r <= cnt_r;
        end else if (at_end_s) begin
            cnt_r <= 16'd0;
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

endmodule

// File: rtl/nco_i2c_cfg_master.sv
// nco_i2c_cfg_master: write-only I2C master pushing control/frequency/duty to the NCO slave.
// Optional slave clock stretching is enabled by defining NCO_I2C_STRETCH_EN.
module nco_i2c_cfg_master
    import nco_i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h6A,
    parameter int unsigned QUARTER    = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        cfg_enable,
    input  logic        cfg_wave,
    input  logic        cfg_send_freq,
    input  logic        cfg_send_duty,
    input  logic [63:0] cfg_freq,
    input  logic [15:0] cfg_duty,
    output logic        busy,
    output logic        done,
    output logic        nack,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        scl_i,
    input  logic        sda_i
);

    state_t      state_r, state_nx;
    logic [1:0]  phase_r, phase_nx;
    logic [2:0]  bit_r, bit_nx;
    logic [3:0]  byte_r, byte_nx;
    logic [3:0]  nbytes_r, nbytes_nx;
    logic [95:0] frame_r, frame_nx;
    logic        ackerr_r, ackerr_nx;
    logic        req_ready_r, busy_r, done_r, nack_r, scl_oe_r, sda_oe_r;
    logic [7:0]  ctrl_s;
    logic        accept_s, run_s, hold_s, tick_s;
    logic [1:0]  drive_s;

    // Whole transfer is packed MSB-first so the current bit is always frame_r[95].
    function automatic logic [95:0] build_frame(input logic [7:0] a, input logic [7:0] c,
                                                input logic f, input logic d,
                                                input logic [63:0] fq, input logic [15:0] dt);
        case ({f, d})
            2'b11:   build_frame = {a, c, fq, dt};
            2'b10:   build_frame = {a, c, fq, 16'h0000};
            2'b01:   build_frame = {a, c, dt, 64'h0};
            default: build_frame = {a, c, 80'h0};
        endcase
    endfunction

    // Returns {scl_oe, sda_oe} for a given state/phase and outgoing data bit.
    function automatic logic [1:0] line_drive(input state_t st, input logic [1:0] ph, input logic b);
        case (st)
            ST_START_B: line_drive = 2'b01;
            ST_BIT:     line_drive = {(ph == 2'd0) || (ph == 2'd3), ~b};
            ST_ACK:     line_drive = {(ph == 2'd0) || (ph == 2'd3), 1'b0};
            ST_STOP_A:  line_drive = 2'b11;
            ST_STOP_B:  line_drive = 2'b01;
            default:    line_drive = 2'b00;
        endcase
    endfunction

    // Control byte assembly from the request flags.
    always_comb begin
        ctrl_s         = 8'h00;
        ctrl_s[CTRL_E] = cfg_enable;
        ctrl_s[CTRL_S] = cfg_wave;
        ctrl_s[CTRL_F] = cfg_send_freq;
        ctrl_s[CTRL_D] = cfg_send_duty;
    end

    assign accept_s = (state_r == ST_IDLE) && req_valid;
    assign run_s    = (state_r != ST_IDLE) && (state_r != ST_DONE);

`ifdef NCO_I2C_STRETCH_EN
    assign hold_s = ((state_r == ST_BIT) || (state_r == ST_ACK)) && (phase_r == 2'd1) && !scl_i;
`else
    logic unused_scl_s;
    assign unused_scl_s = scl_i;
    assign hold_s       = 1'b0;
`endif

    i2c_quarter_tick #(.QUARTER(QUARTER)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .run  (run_s),
        .hold (hold_s),
        .tick (tick_s)
    );

    // Next-state logic: phases advance only on quarter ticks.
    always_comb begin
        state_nx  = state_r;
        phase_nx  = phase_r;
        bit_nx    = bit_r;
        byte_nx   = byte_r;
        frame_nx  = frame_r;
        nbytes_nx = nbytes_r;
        ackerr_nx = ackerr_r;
        if (accept_s) begin
            state_nx  = ST_START_A;
            phase_nx  = 2'd0;
            bit_nx    = 3'd7;
            byte_nx   = 4'd0;
            ackerr_nx = 1'b0;
            nbytes_nx = n_bytes(cfg_send_freq, cfg_send_duty);
            frame_nx  = build_frame({SLAVE_ADDR, 1'b0}, ctrl_s, cfg_send_freq, cfg_send_duty,
                                    cfg_freq, cfg_duty);
        end else if (state_r == ST_DONE) begin
            state_nx = ST_IDLE;
        end else if (tick_s) begin
            case (state_r)
                ST_START_A: state_nx = ST_START_B;
                ST_START_B: state_nx = ST_BIT;
                ST_BIT: begin
                    phase_nx = phase_r + 2'd1;
                    if (phase_r == 2'd3) begin
                        frame_nx = {frame_r[94:0], 1'b0};
                        if (bit_r == 3'd0) begin
                            state_nx = ST_ACK;
                        end else begin
                            bit_nx = bit_r - 3'd1;
                        end
                    end else begin
                        frame_nx = frame_r;
                    end
                end
                ST_ACK: begin
                    phase_nx = phase_r + 2'd1;
                    // The tick in p2 is exactly its last clock: the ACK sample point.
                    if (phase_r == 2'd2) begin
                        ackerr_nx = ackerr_r | sda_i;
                    end else begin
                        ackerr_nx = ackerr_r;
                    end
                    if (phase_r == 2'd3) begin
                        bit_nx = 3'd7;
                        if (ackerr_r || (byte_r == nbytes_r - 4'd1)) begin
                            state_nx = ST_STOP_A;
                        end else begin
                            state_nx = ST_BIT;
                            byte_nx  = byte_r + 4'd1;
                        end
                    end else begin
                        bit_nx = bit_r;
                    end
                end
                ST_STOP_A: state_nx = ST_STOP_B;
                ST_STOP_B: state_nx = ST_STOP_C;
                ST_STOP_C: state_nx = ST_DONE;
                default:   state_nx = ST_IDLE;
            endcase
        end else begin
            state_nx = state_r;
        end
    end

    assign drive_s = line_drive(state_nx, phase_nx, frame_nx[95]);

    // State and registered outputs, decoded from the next state so pads track phases exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            phase_r     <= 2'd0;
            bit_r       <= 3'd7;
            byte_r      <= 4'd0;
            nbytes_r    <= 4'd2;
            frame_r     <= 96'h0;
            ackerr_r    <= 1'b0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            nack_r      <= 1'b0;
            scl_oe_r    <= 1'b0;
            sda_oe_r    <= 1'b0;
        end else begin
            state_r     <= state_nx;
            phase_r     <= phase_nx;
            bit_r       <= bit_nx;
            byte_r      <= byte_nx;
            nbytes_r    <= nbytes_nx;
            frame_r     <= frame_nx;
            ackerr_r    <= ackerr_nx;
            req_ready_r <= (state_nx == ST_IDLE);
            busy_r      <= (state_nx != ST_IDLE) && (state_nx != ST_DONE);
            done_r      <= (state_nx == ST_DONE);
            scl_oe_r    <= drive_s[1];
            sda_oe_r    <= drive_s[0];
            if (accept_s) begin
                nack_r <= 1'b0;
            end else if (state_nx == ST_DONE) begin
                nack_r <= ackerr_r;
            end else begin
                nack_r <= nack_r;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign nack      = nack_r;
    assign scl_oe    = scl_oe_r;
    assign sda_oe    = sda_oe_r;

endmodule

// File: tb/tb_nco_i2c_cfg_master.sv
// tb_nco_i2c_cfg_master: quarter-level bus model plus a bit-level I2C slave that
// decodes bytes and ACKs/NACKs them, with directed and randomized transfers.
module tb_nco_i2c_cfg_master;

    localparam int Q = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        cfg_enable = 1'b0, cfg_wave = 1'b0, cfg_send_freq = 1'b0, cfg_send_duty = 1'b0;
    logic [63:0] cfg_freq = 64'h0;
    logic [15:0] cfg_duty = 16'h0;
    logic        req_ready, busy, done, nack, scl_oe, sda_oe, scl_i, sda_i;
    logic        slave_pull = 1'b0;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    assign scl_i = ~scl_oe;
    assign sda_i = ~(sda_oe | slave_pull);

    always #5 clk = ~clk;

    nco_i2c_cfg_master #(.SLAVE_ADDR(7'h6A), .QUARTER(Q)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .cfg_enable(cfg_enable), .cfg_wave(cfg_wave), .cfg_send_freq(cfg_send_freq),
        .cfg_send_duty(cfg_send_duty), .cfg_freq(cfg_freq), .cfg_duty(cfg_duty),
        .busy(busy), .done(done), .nack(nack), .scl_oe(scl_oe), .sda_oe(sda_oe),
        .scl_i(scl_i), .sda_i(sda_i)
    );

    task automatic chk1(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chkv(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model: one {scl_oe,sda_oe} entry per quarter
    logic [1:0] sched[$];
    logic [7:0] exp_bytes[$];
    int         pos = 0;
    int         nack_at = 99;
    bit         m_nack_res = 1'b0;
    logic       e_ready = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_nack = 1'b0, e_scl = 1'b0, e_sda = 1'b0;

    task automatic build_model();
        logic [7:0] b[$];
        logic [7:0] cur;
        logic       d;
        b = {};
        b.push_back(8'hD4);
        b.push_back({4'b0000, cfg_send_duty, cfg_send_freq, cfg_wave, cfg_enable});
        if (cfg_send_freq) for (int i = 7; i >= 0; i--) b.push_back(cfg_freq[i*8 +: 8]);
        if (cfg_send_duty) begin
            b.push_back(cfg_duty[15:8]);
            b.push_back(cfg_duty[7:0]);
        end
        sched = {};
        exp_bytes = {};
        m_nack_res = 1'b0;
        sched.push_back(2'b00);
        sched.push_back(2'b01);
        for (int j = 0; j < b.size(); j++) begin
            cur = b[j];
            exp_bytes.push_back(cur);
            for (int k = 7; k >= 0; k--) begin
                d = ~cur[k];
                sched.push_back({1'b1, d});
                sched.push_back({1'b0, d});
                sched.push_back({1'b0, d});
                sched.push_back({1'b1, d});
            end
            sched.push_back(2'b10);
            sched.push_back(2'b00);
            sched.push_back(2'b00);
            sched.push_back(2'b10);
            if (j == nack_at) begin
                m_nack_res = 1'b1;
                break;
            end
        end
        sched.push_back(2'b11);
        sched.push_back(2'b01);
        sched.push_back(2'b00);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            e_ready = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_nack = 1'b0; e_scl = 1'b0; e_sda = 1'b0;
        end else if (e_ready) begin
            if (req_valid) begin
                build_model();
                pos = 0;
                e_ready = 1'b0; e_busy = 1'b1; e_nack = 1'b0;
                {e_scl, e_sda} = sched[0];
            end
        end else begin
            pos++;
            if (pos < sched.size() * Q) begin
                {e_scl, e_sda} = sched[pos / Q];
            end else if (pos == sched.size() * Q) begin
                e_busy = 1'b0; e_done = 1'b1; e_nack = m_nack_res; e_scl = 1'b0; e_sda = 1'b0;
            end else begin
                e_done = 1'b0; e_ready = 1'b1;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk1("req_ready", req_ready, e_ready);
            chk1("busy", busy, e_busy);
            chk1("done", done, e_done);
            chk1("nack", nack, e_nack);
            chk1("scl_oe", scl_oe, e_scl);
            chk1("sda_oe", sda_oe, e_sda);
        end
    end

    // ---------------- bit-level slave: decodes bytes and drives ACK on SDA
    logic [7:0] rx[$];
    logic [7:0] sh = 8'h00;
    logic       scl_p = 1'b1, sda_p = 1'b1;
    int         bitn = 0, rx_idx = 0, starts = 0, stops = 0;
    bit         ack_phase = 1'b0;

    always @(negedge clk) begin
        logic scl_l, sda_l;
        scl_l = scl_i;
        sda_l = sda_i;
        if (chk_on) begin
            if (scl_p && scl_l && sda_p && !sda_l) begin
                starts++; bitn = 0; rx_idx = 0; ack_phase = 1'b0; slave_pull = 1'b0;
            end else if (scl_p && scl_l && !sda_p && sda_l) begin
                stops++;
            end else if (!scl_p && scl_l) begin
                if (bitn < 8) begin
                    sh = {sh[6:0], sda_l};
                    bitn++;
                    if (bitn == 8) rx.push_back(sh);
                end
            end else if (scl_p && !scl_l) begin
                if (bitn == 8 && !ack_phase) begin
                    slave_pull = (rx_idx != nack_at);
                    ack_phase = 1'b1;
                end else if (ack_phase) begin
                    slave_pull = 1'b0; ack_phase = 1'b0; bitn = 0; rx_idx++;
                end
            end
            scl_p = scl_l;
            sda_p = sda_l;
        end
    end

    task automatic run_txn(input logic e, input logic s, input logic f, input logic d,
                           input logic [63:0] fq, input logic [15:0] dt, input int nk, output int lat);
        int st0, sp0, nb, sent;
        nb = 2 + (f ? 8 : 0) + (d ? 2 : 0);
        sent = (nk < nb) ? nk + 1 : nb;
        @(negedge clk);
        rx.delete();
        nack_at = nk;
        cfg_enable = e; cfg_wave = s; cfg_send_freq = f; cfg_send_duty = d;
        cfg_freq = fq; cfg_duty = dt;
        st0 = starts; sp0 = stops;
        req_valid = 1'b1;
        @(negedge clk);
        lat = 0;
        while (done !== 1'b1 && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        req_valid = 1'b0;
        chk1("done_seen", done, 1'b1);
        chkv("latency", 64'(lat), 64'((5 + 36 * sent) * Q));
        chk1("nack_at_done", nack, (nk < nb));
        chkv("rx_count", 64'(rx.size()), 64'(sent));
        for (int i = 0; i < sent && i < rx.size() && i < exp_bytes.size(); i++)
            chkv("rx_byte", 64'(rx[i]), 64'(exp_bytes[i]));
        chkv("start_count", 64'(starts - st0), 64'd1);
        chkv("stop_count", 64'(stops - sp0), 64'd1);
    endtask

    initial begin
        int         lat, nb, nk;
        logic       f, d;
        logic [63:0] fr;

        @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_lines", scl_oe | sda_oe, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Ctrl only: literal bytes and 77-quarter latency.
        run_txn(1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 16'h0, 99, lat);
        chkv("t1_latency", 64'(lat), 64'd308);
        chkv("t1_addr", 64'(rx.size() > 0 ? rx[0] : 8'h00), 64'hD4);
        chkv("t1_ctrl", 64'(rx.size() > 1 ? rx[1] : 8'h00), 64'h03);
        chk1("t1_nack", nack, 1'b0);

        // Frequency group.
        run_txn(1'b0, 1'b0, 1'b1, 1'b0, 64'hA5A5A5A5A5A5A5A5, 16'h0, 99, lat);
        chkv("t2_ctrl", 64'(rx.size() > 1 ? rx[1] : 8'h00), 64'h04);
        fr = 64'h0;
        for (int i = 0; i < 8; i++) fr = {fr[55:0], (rx.size() > 2 + i) ? rx[2 + i] : 8'h00};
        chkv("t2_freq_reg", fr, 64'hA5A5A5A5A5A5A5A5);

        // Frequency and duty.
        run_txn(1'b1, 1'b0, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 16'h1234, 99, lat);
        chkv("t3_count", 64'(rx.size()), 64'd12);
        chkv("t3_duty_reg", 64'({(rx.size() > 10) ? rx[10] : 8'h00, (rx.size() > 11) ? rx[11] : 8'h00}), 64'h1234);

        // Address refused by the slave.
        run_txn(1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 16'h0, 0, lat);
        chkv("t4_count", 64'(rx.size()), 64'd1);
        chk1("t4_nack", nack, 1'b1);

        // Reset during the freq bytes: lines released next edge, no done.
        @(negedge clk);
        nack_at = 99;
        cfg_send_freq = 1'b1; cfg_send_duty = 1'b0; cfg_freq = 64'h0123456789ABCDEF;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat ((2 + 36 * 7 + 12) * Q) @(negedge clk);
        rst = 1'b1;
        slave_pull = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk1("abort_scl", scl_oe, 1'b0);
        chk1("abort_sda", sda_oe, 1'b0);
        chk1("abort_ready", req_ready, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk1("abort_no_done", done, 1'b0);
        end
        run_txn(1'b1, 1'b0, 1'b0, 1'b1, 64'h0, 16'hBEEF, 99, lat);

        // Randomized transfers, some with a refused byte.
        for (int t = 0; t < 12; t++) begin
            f = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            nb = 2 + (f ? 8 : 0) + (d ? 2 : 0);
            nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : 99;
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f, d,
                    {$urandom, $urandom}, 16'($urandom), nk, lat);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
